// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the seven-segment scan controller: a packed hex value plus
// per-digit decimal-point and blanking masks, transferred with valid/ready.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dp;
  logic [DIGITS-1:0]     wr_blank;

  // Producer side: drives the request and holds its payload until accepted.
  modport master (
    output wr_valid,
    output wr_data,
    output wr_dp,
    output wr_blank,
    input  wr_ready
  );

  // Controller side.
  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_dp,
    input  wr_blank,
    output wr_ready
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for DIGITS common-anode seven-segment
// digits with frame-aligned commit of staged writes and dead-time blanking.
module seg7_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 2
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_ctrl_if.slave    wr,
  output logic [6:0]         seg_n,
  output logic               dp_n,
  output logic [DIGITS-1:0]  an_n,
  output logic               frame_tick
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    PH_DEAD  = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // With no dead time the very first slot cycle already drives.
  localparam phase_e PH_RESET = (BLANK == 0) ? PH_DRIVE : PH_DEAD;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan position and slot phase.
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  phase_e              phase_q, phase_d;
  logic                boundary;

  // Staged and displayed frame contents.
  logic [4*DIGITS-1:0] stage_data_q, active_data_q;
  logic [DIGITS-1:0]   stage_dp_q, active_dp_q;
  logic [DIGITS-1:0]   stage_blank_q, active_blank_q;
  logic                pending_q;
  logic                accept;

  // Next values of the registered display outputs.
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   an_d;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  assign cur_nib   = active_data_q[{idx_q, 2'b00} +: 4];
  assign cur_dp    = active_dp_q[idx_q];
  assign cur_blank = active_blank_q[idx_q];

  assign boundary  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Only one write may be outstanding; the producer sees ready until staging fills.
  assign wr.wr_ready = ~pending_q;
  assign accept      = wr.wr_valid && ~pending_q;

  // Next-state and output decode for the per-slot phase machine.
  // NOTE: every signal is given a default first so no path leaves one unassigned (no latches).
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    an_d  = '1;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    phase_d = (cnt_d < CNT_BLANK) ? PH_DEAD : PH_DRIVE;

    case (phase_q)
      PH_DRIVE: begin
        if (!cur_blank) begin
          an_d[idx_q] = 1'b0;
          seg_d       = hex_to_seg(cur_nib);
          dp_d        = ~cur_dp;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= PH_RESET;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  // Commit at a frame boundary has priority; a write can only be staged
  // while nothing is pending, so the two branches never compete for one write.
  // NOTE: staging and active registers are reset too, so a discarded write can never surface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_data_q   <= '0;
      stage_dp_q     <= '0;
      stage_blank_q  <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
      pending_q      <= 1'b0;
    end else if (boundary && pending_q) begin
      active_data_q  <= stage_data_q;
      active_dp_q    <= stage_dp_q;
      active_blank_q <= stage_blank_q;
      pending_q      <= 1'b0;
    end else if (accept) begin
      stage_data_q   <= wr.wr_data;
      stage_dp_q     <= wr.wr_dp;
      stage_blank_q  <= wr.wr_blank;
      pending_q      <= 1'b1;
    end
  end

  // Registered pin drivers, one cycle behind the scan position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_n      <= 7'b1111111;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised self-checking bench for seg7_scan_ctrl against a time-indexed
// reference model of the scan, staging and frame-commit rules.
module tb_seg7_scan_ctrl;

  localparam int D  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = D * P;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   seg_n;
  logic         dp_n;
  logic [D-1:0] an_n;
  logic         frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_ctrl_if #(.DIGITS(D)) wr_bus ();

  seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_bus),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: scan position follows purely from edges since reset.
  logic [6:0]    seg_tab [16];
  int            m_n;
  logic [15:0]   m_act_data, m_stg_data;
  logic [3:0]    m_act_dp, m_stg_dp, m_act_blank, m_stg_blank;
  bit            m_pending, m_accepted;
  logic [6:0]    e_seg;
  logic          e_dp, e_tick, e_ready;
  logic [D-1:0]  e_an;

  task automatic model_reset();
    m_n = 0;
    m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
    m_stg_data = '0; m_stg_dp = '0; m_stg_blank = '0;
    m_pending = 0; m_accepted = 0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_tick = 1'b0; e_ready = 1'b1;
  endtask

  // Advance one clock, predict the outputs that edge produces, sample at negedge.
  task automatic step();
    int c, i;
    @(posedge clk);
    c = m_n % P;
    i = (m_n / P) % D;
    if (c < B || m_act_blank[i]) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << i);
      e_seg = seg_tab[m_act_data[i*4 +: 4]];
      e_dp  = ~m_act_dp[i];
    end
    e_tick = ((m_n % FR) == FR - 1);
    m_accepted = 0;
    if (e_tick && m_pending) begin
      m_act_data = m_stg_data; m_act_dp = m_stg_dp; m_act_blank = m_stg_blank;
      m_pending = 0;
    end else if (wr_bus.wr_valid && !m_pending) begin
      m_stg_data = wr_bus.wr_data; m_stg_dp = wr_bus.wr_dp; m_stg_blank = wr_bus.wr_blank;
      m_pending = 1; m_accepted = 1;
    end
    e_ready = !m_pending;
    m_n++;
    @(negedge clk);
  endtask

  function automatic string got_exp();
    return $sformatf("t=%0d got seg=%b dp=%b an=%b tick=%b rdy=%b exp seg=%b dp=%b an=%b tick=%b rdy=%b",
                     m_n, seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready,
                     e_seg, e_dp, e_an, e_tick, e_ready);
  endfunction

  // Present a write and hold it until the model accepts it; every cycle is compared.
  task automatic drive_write(input string tag, input logic [15:0] d,
                             input logic [3:0] p, input logic [3:0] bl);
    bit done = 0;
    wr_bus.wr_valid = 1'b1; wr_bus.wr_data = d; wr_bus.wr_dp = p; wr_bus.wr_blank = bl;
    for (int k = 0; k < 4 * FR && !done; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL %s_wr %s", tag, got_exp());
      end
      if (m_accepted) done = 1;
    end
    wr_bus.wr_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s_accept_timeout got accepted=0 exp accepted=1", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_bus.wr_valid = 1'b0; wr_bus.wr_data = '0; wr_bus.wr_dp = '0; wr_bus.wr_blank = '0;
    repeat (2) @(negedge clk);
    model_reset();
    n_checks++;
    if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_values %s", got_exp());
    end
    reset = 1'b1;
  endtask

  task automatic test_scan();
    int ticks = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL scan %s", got_exp());
      end
      if (frame_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 2) begin
      n_fail++; $display("FAIL scan_tick_count got %0d exp 2", ticks);
    end
  endtask

  task automatic test_write();
    bit seen_a_dp = 0;
    repeat (5) step();
    drive_write("write", 16'h3A7F, 4'b0100, 4'b0000);
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL write %s", got_exp());
      end
      if (an_n === 4'b1011 && seg_n === 7'b0001000 && dp_n === 1'b0) seen_a_dp = 1;
    end
    n_checks++;
    if (!seen_a_dp) begin
      n_fail++; $display("FAIL write_digit2 got seen=0 exp seen=1");
    end
  endtask

  task automatic test_back_to_back();
    drive_write("b2b_first", 16'($urandom), 4'($urandom), 4'b0000);
    drive_write("b2b_second", 16'($urandom), 4'($urandom), 4'b0000);
    for (int k = 0; k < 2 * FR + 8; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL back_to_back %s", got_exp());
      end
    end
  endtask

  task automatic test_boundary_write();
    bit found = 0;
    for (int k = 0; k < 4 * FR && !found; k++) begin
      if (!m_pending && (m_n % FR) == FR - 1) found = 1;
      else step();
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL boundary_align got found=0 exp found=1");
    end
    wr_bus.wr_valid = 1'b1; wr_bus.wr_data = 16'($urandom);
    wr_bus.wr_dp = 4'($urandom); wr_bus.wr_blank = 4'b0000;
    step();
    wr_bus.wr_valid = 1'b0;
    n_checks++;
    if ({frame_tick, wr_bus.wr_ready} !== 2'b10) begin
      n_fail++; $display("FAIL boundary_accept got tick=%b rdy=%b exp tick=1 rdy=0", frame_tick, wr_bus.wr_ready);
    end
    for (int k = 0; k < 2 * FR + 4; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL boundary_write %s", got_exp());
      end
    end
  endtask

  task automatic test_blank();
    int driven_dark = 0;
    drive_write("blank", 16'($urandom), 4'b1111, 4'b1010);
    for (int k = 0; k < 2 * FR && !e_ready; k++) step();
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL blank %s", got_exp());
      end
      if (an_n[1] === 1'b0 || an_n[3] === 1'b0) driven_dark++;
    end
    n_checks++;
    if (driven_dark != 0) begin
      n_fail++; $display("FAIL blank_anodes got %0d driven cycles exp 0", driven_dark);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int gap = $urandom_range(0, 40);
      for (int k = 0; k < gap; k++) begin
        step();
        n_checks++;
        if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
          n_fail++; $display("FAIL random %s", got_exp());
        end
      end
      drive_write("random", 16'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    drive_write("rst_mid", 16'hFFFF, 4'b1111, 4'b0000);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_async got seg=%b dp=%b an=%b tick=%b rdy=%b", seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL reset_hold got seg=%b dp=%b an=%b tick=%b rdy=%b", seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready);
      end
    end
    model_reset();
    reset = 1'b1;
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      n_checks++;
      if ({seg_n, dp_n, an_n, frame_tick, wr_bus.wr_ready} !== {e_seg, e_dp, e_an, e_tick, e_ready}) begin
        n_fail++; $display("FAIL reset_restart %s", got_exp());
      end
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_scan();
    test_write();
    test_back_to_back();
    test_boundary_write();
    test_blank();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
